fetch_unit: RTL and testbench

Instruction fetch stage of the RISC-V core, directly upstream of the decoder/control unit. It owns the program counter, issues word reads to instruction memory over a valid/ready request channel, and buffers returned instructions in a small in-order FIFO. Each instruction is presented to decode with its PC and pre-sliced opcode/funct3/funct7 fields. Taken jumps and branches from later stages redirect the PC; in-flight stale responses are squashed.

---
 rtl/fetch_unit.sv | 170 +++++++++++++++++
 tb/tb_fetch_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the program counter, issues word reads to
// instruction memory over a valid/ready channel, and buffers returned words
// in a small in-order FIFO that feeds decode with {instr, pc} pairs.
// Redirects flush the FIFO and squash responses to requests already in flight.
module fetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_req_ready,
  input  logic            imem_resp_valid,
  input  logic [31:0]     imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  output logic [31:0]     instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  input  logic            instr_ready
);

  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int CW1 = CW + 1;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [XLEN-1:0] r_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   w_outstanding_next;
  logic [CW-1:0]   r_count;

  // Instruction FIFO and the shadow queue of PCs for outstanding requests.
  logic [AW-1:0]   r_rd_ptr;
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_pcq_rd;
  logic [AW-1:0]   r_pcq_wr;
  logic [31:0]     r_fifo_instr [DEPTH];
  logic [XLEN-1:0] r_fifo_pc    [DEPTH];
  logic [XLEN-1:0] r_pcq        [DEPTH];

  logic            w_pop;
  logic            w_push;
  logic            w_req_fire;
  logic            w_credit;
  logic [CW1-1:0]  w_occupancy;
  logic [CW1-1:0]  w_limit;
  logic [XLEN-1:0] w_redirect_target;
  logic [1:0]      w_unused_redirect_lsbs;

  assign instr_valid = (r_count != '0);
  assign w_pop       = instr_valid && instr_ready;
  assign w_req_fire  = imem_req_valid && imem_req_ready;

  // A response is kept only when it belongs to a live request: stale ones
  // arrive while draining or in the very cycle of a redirect.
  assign w_push = imem_resp_valid && (r_state == S_FETCH) && !redirect_valid;

  // Credit counts in-flight requests plus buffered words; the head leaving
  // this cycle frees its slot early so DEPTH=2 sustains one word per cycle
  // with single-cycle memory.
  assign w_occupancy = CW1'(r_outstanding) + CW1'(r_count);
  assign w_limit     = CW1'(DEPTH) + CW1'(w_pop);
  assign w_credit    = (w_occupancy < w_limit);

  // Every response retires one outstanding request, stale or not.
  assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(imem_resp_valid);

  assign w_redirect_target      = {redirect_pc[XLEN-1:2], 2'b00};
  assign w_unused_redirect_lsbs = redirect_pc[1:0];

  // FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the blocks are evaluated in.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_BOOT;
    else     r_state <= w_state_next;
  end

  // FSM next-state: redirect decides between draining stale requests or
  // fetching straight away; otherwise BOOT lasts one cycle and DRAIN ends
  // once the last stale response has come back.
  // NOTE: each combinational output gets a default first so no path leaves
  // it unassigned, which would infer a latch.
  always_comb begin
    w_state_next = r_state;
    if (redirect_valid) begin
      w_state_next = (w_outstanding_next != '0) ? S_DRAIN : S_FETCH;
    end else begin
      case (r_state)
        S_BOOT:  w_state_next = S_FETCH;
        S_FETCH: w_state_next = S_FETCH;
        S_DRAIN: if (w_outstanding_next == '0) w_state_next = S_FETCH;
        default: w_state_next = S_BOOT;
      endcase
    end
  end

  // FSM outputs: requests only while fetching and credit is available.
  always_comb begin
    imem_req_valid = 1'b0;
    imem_req_addr  = r_pc;
    if (r_state == S_FETCH) imem_req_valid = w_credit;
  end

  // PC, outstanding counter, FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc          <= RESET_PC;
      r_outstanding <= '0;
      r_count       <= '0;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_pcq_rd      <= '0;
      r_pcq_wr      <= '0;
    end else begin
      r_outstanding <= w_outstanding_next;
      if (redirect_valid) begin
        r_pc     <= w_redirect_target;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_pcq_rd <= '0;
        r_pcq_wr <= '0;
      end else begin
        if (w_req_fire) begin
          r_pc     <= r_pc + XLEN'(4);
          r_pcq_wr <= r_pcq_wr + 1'b1;
        end
        if (w_push) begin
          r_pcq_rd <= r_pcq_rd + 1'b1;
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage for buffered words and request PCs.
  // NOTE: storage arrays carry no reset; occupancy and pointers alone decide
  // which entries are meaningful, so clearing the data would only cost area.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_instr[r_wr_ptr] <= imem_resp_data;
      r_fifo_pc[r_wr_ptr]    <= r_pcq[r_pcq_rd];
    end
    if (w_req_fire && !redirect_valid) r_pcq[r_pcq_wr] <= r_pc;
  end

  assign instr    = r_fifo_instr[r_rd_ptr];
  assign instr_pc = r_fifo_pc[r_rd_ptr];
  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign funct7   = instr[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. A behavioural memory answers accepted
// requests in order after a chosen latency; the reference model tracks the
// architectural instruction stream (sequential PCs, restarted by redirects)
// and the number of words the stage may hold.
module tb_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        instr_ready;

  fetch_unit #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .instr_ready    (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;

  mreq_t       mq[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_due = 0;
  int          lat = 1;
  int          ready_pct = 100;
  int          dec_pct = 100;
  int          redir_pct = 0;
  logic [31:0] exp_pc = RESET_PC;
  logic [31:0] exp_req_addr = RESET_PC;
  int          stale_left = 0;
  int          buffered = 0;
  int          delivered = 0;
  logic        hold_pending = 1'b0;
  logic [31:0] held_pc;
  logic [31:0] held_instr;
  logic        s_req_valid;
  logic [31:0] s_req_addr;
  logic        s_instr_valid;
  logic [31:0] s_pop_pc;
  logic [31:0] last_pop_pc = 32'h1;
  logic        saw_wrap = 1'b0;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ {a[15:0], a[31:16]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs, then advance the model
  // by what the handshakes did at the edge.
  // mode 0: random redirect, 1: forced redirect, 2: redirect only together
  // with a response and a decode pop.
  task automatic do_cycle(input int mode, input logic [31:0] tgt, input logic do_rst,
                          output logic fired);
    logic        fire;
    logic        pop;
    logic        resp;
    logic        redir;
    logic [31:0] addr_s;
    logic [31:0] exp_instr;
    logic [31:0] tgt_s;
    int          due;
    #1;
    cyc++;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_data(mq[0].addr);
    end
    imem_req_ready = ($urandom_range(99) < ready_pct);
    instr_ready    = ($urandom_range(99) < dec_pct);
    redirect_valid = 1'b0;
    redirect_pc    = $urandom;
    case (mode)
      1: begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
      end
      2: if (imem_resp_valid && instr_valid) begin
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        instr_ready    = 1'b1;
      end
      default: if ($urandom_range(99) < redir_pct) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom & 32'h0000_3FFF;
      end
    endcase
    rst   = do_rst;
    fired = redirect_valid;
    #1;
    fire   = imem_req_valid && imem_req_ready;
    pop    = instr_valid && instr_ready;
    resp   = imem_resp_valid;
    redir  = redirect_valid;
    addr_s = imem_req_addr;
    tgt_s  = {redirect_pc[31:2], 2'b00};
    s_req_valid   = imem_req_valid;
    s_req_addr    = imem_req_addr;
    s_instr_valid = instr_valid;
    if (!do_rst) begin
      if (hold_pending) begin
        check("hold_valid", 32'(instr_valid), 32'd1);
        check("hold_pc", instr_pc, held_pc);
        check("hold_instr", instr, held_instr);
      end
      check("instr_valid", 32'(instr_valid), 32'(buffered > 0));
      check("credit", 32'(mq.size() + buffered <= DEPTH), 32'd1);
      if (stale_left > 0) check("drain_no_req", 32'(imem_req_valid), 32'd0);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_req_addr);
      if (pop) begin
        exp_instr = mem_data(exp_pc);
        check("instr_pc", instr_pc, exp_pc);
        check("instr", instr, exp_instr);
        check("opcode", 32'(opcode), 32'(exp_instr[6:0]));
        check("funct3", 32'(funct3), 32'(exp_instr[14:12]));
        check("funct7", 32'(funct7), 32'(exp_instr[31:25]));
        if (instr_pc == 32'h0 && last_pop_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
        last_pop_pc = instr_pc;
        s_pop_pc    = instr_pc;
        exp_pc      = exp_pc + 32'd4;
        delivered++;
      end
    end
    hold_pending = instr_valid && !instr_ready && !redir && !do_rst;
    held_pc      = instr_pc;
    held_instr   = instr;
    @(posedge clk);
    if (do_rst) begin
      mq.delete();
      last_due     = 0;
      stale_left   = 0;
      buffered     = 0;
      exp_pc       = RESET_PC;
      exp_req_addr = RESET_PC;
    end else begin
      if (resp) begin
        void'(mq.pop_front());
        if (stale_left > 0) stale_left--;
        else if (!redir) buffered++;
      end
      if (fire) begin
        due = cyc + lat;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mq.push_back('{addr: addr_s, due: due});
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (pop) buffered--;
      if (redir) begin
        buffered     = 0;
        stale_left   = mq.size();
        exp_pc       = tgt_s;
        exp_req_addr = tgt_s;
      end
    end
  endtask

  initial begin
    logic f;
    int   d0;
    int   n;
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    redirect_valid  = 1'b0;
    redirect_pc     = '0;
    instr_ready     = 1'b0;
    @(posedge clk);

    // Reset, then one BOOT cycle, then the first request to RESET_PC.
    do_cycle(0, 0, 1'b1, f);
    do_cycle(0, 0, 1'b1, f);
    check("rst_req_valid", 32'(s_req_valid), 32'd0);
    check("rst_instr_valid", 32'(s_instr_valid), 32'd0);
    do_cycle(0, 0, 1'b0, f);
    check("boot_no_req", 32'(s_req_valid), 32'd0);
    do_cycle(0, 0, 1'b0, f);
    check("first_req_valid", 32'(s_req_valid), 32'd1);
    check("first_req_addr", s_req_addr, RESET_PC);

    // Always-ready memory and decode: one instruction per cycle after fill.
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 1'b0, f);
    d0 = delivered;
    for (int i = 0; i < 20; i++) do_cycle(0, 0, 1'b0, f);
    check("throughput", 32'(delivered - d0), 32'd20);

    // Decode stalled for 10 cycles, then released.
    dec_pct = 0;
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 1'b0, f);
    dec_pct = 100;
    d0 = delivered;
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 1'b0, f);
    check("stall_release", 32'(delivered - d0 > 0), 32'd1);

    // Redirect to 0x100 with two requests in flight at latency 3.
    lat = 3;
    n = 0;
    while (mq.size() < 2 && n < 20) begin
      do_cycle(0, 0, 1'b0, f);
      n++;
    end
    do_cycle(1, 32'h100, 1'b0, f);
    check("redir_stale", 32'(stale_left > 0), 32'd1);
    d0 = delivered;
    n = 0;
    while (delivered == d0 && n < 30) begin
      do_cycle(0, 0, 1'b0, f);
      n++;
    end
    check("redir_first_pc", s_pop_pc, 32'h100);

    // Redirect to 0x203 together with a response and a decode pop.
    lat = 1;
    f = 1'b0;
    n = 0;
    while (!f && n < 50) begin
      do_cycle(2, 32'h203, 1'b0, f);
      n++;
    end
    check("redir_resp_pop", 32'(f), 32'd1);
    n = 0;
    do begin
      do_cycle(0, 0, 1'b0, f);
      n++;
    end while (!s_req_valid && n < 10);
    check("redir_align_addr", s_req_addr, 32'h200);
    for (int i = 0; i < 10; i++) do_cycle(0, 0, 1'b0, f);

    // PC wraps from 0xFFFF_FFFC to 0.
    do_cycle(1, 32'hFFFF_FFF4, 1'b0, f);
    for (int i = 0; i < 20; i++) do_cycle(0, 0, 1'b0, f);
    check("wrap_seen", 32'(saw_wrap), 32'd1);

    // Reset in the middle of a drain, with redirect held high.
    lat = 6;
    n = 0;
    while (mq.size() < 1 && n < 20) begin
      do_cycle(0, 0, 1'b0, f);
      n++;
    end
    do_cycle(1, 32'h400, 1'b0, f);
    check("drain_entered", 32'(stale_left > 0), 32'd1);
    do_cycle(1, 32'h800, 1'b1, f);
    do_cycle(0, 0, 1'b1, f);
    check("rst_drain_req", 32'(s_req_valid), 32'd0);
    check("rst_drain_instr", 32'(s_instr_valid), 32'd0);
    lat = 1;
    do_cycle(0, 0, 1'b0, f);
    check("rst_boot_no_req", 32'(s_req_valid), 32'd0);
    do_cycle(0, 0, 1'b0, f);
    check("rst_first_req", 32'(s_req_valid), 32'd1);
    check("rst_first_addr", s_req_addr, RESET_PC);

    // Random traffic: varying readiness, latency and redirects.
    ready_pct = 70;
    dec_pct   = 60;
    redir_pct = 5;
    for (int i = 0; i < 400; i++) begin
      if (i % 50 == 0) lat = $urandom_range(4, 1);
      do_cycle(0, 0, 1'b0, f);
    end
    ready_pct = 100;
    dec_pct   = 100;
    redir_pct = 0;
    lat       = 1;
    d0 = delivered;
    for (int i = 0; i < 30; i++) do_cycle(0, 0, 1'b0, f);
    check("final_flow", 32'(delivered - d0 > 0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
